mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
// - Multi-cycle sequencer for the 16-bit MIPS datapath: one FSM drives PC, IR, memory, register-file and ALU strobes
//   so a single ALU and a single memory port are time-shared across FETCH/DECODE/EXEC/MEM/WB steps.
// - Sits between the unified memory port (mem_ready handshake) and the datapath muxes. Replaces the single-cycle control unit.
// - Also keeps retired-instruction and cycle counters and halts on HALT or illegal opcodes.
// PARAMETERS
// - CNT_W    16  width of instr_count / cycle_count (saturating)
// - HALT_OP  6'b111111  opcode that stops the machine
// PORTS
// - clk          in   1  clock
// - reset        in   1  asynchronous, active-high reset
// - opcode       in   6  IR[31:26], valid from DECODE onward
// - alu_zero     in   1  ALU zero flag (beq compare)
// - mem_ready    in   1  memory completes the access this cycle
// - pc_write     out  1  unconditional PC load
// - pc_write_cond out 1  PC load if alu_zero (BRANCH only)
// - pc_source    out  2  00 ALU result, 01 ALUOut, 10 jump target
// - ior          out  1  memory address mux: 0 PC, 1 ALUOut
// - mem_read     out  1  memory read request
// - mem_write    out  1  memory write request
// - ir_write     out  1  load instruction register
// - reg_dst      out  1  1 rd, 0 rt
// - memto_reg    out  1  1 MDR, 0 ALUOut
// - reg_write    out  1  register-file write enable
// - alu_src_a    out  1  0 PC, 1 regA
// - alu_src_b    out  2  00 regB, 01 const 1, 10 sign-ext imm, 11 branch offset
// - alu_op       out  2  00 add, 01 sub, 10 funct-decoded (to alu_control_unit)
// - halted       out  1  FSM in HALT
// - illegal_op   out  1  sticky: HALT was entered via unknown opcode
// - instr_count  out  CNT_W  retired instructions
// - cycle_count  out  CNT_W  cycles spent outside HALT
// BEHAVIOUR
// - reset: state=FETCH; every output 0 while reset high (strobes gated), counters 0, halted=0, illegal_op=0.
// - Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, HALT_OP.
// - FETCH: mem_read=1, ior=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write ONLY in the
//   cycle mem_ready=1, then -> DECODE; else stay (no PC/IR change). PC increments by 1 (word-addressed).
// - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target -> ALUOut). Next by opcode: lw/sw->MEM_ADDR,
//   R->EXECUTE, beq->BRANCH, j->JUMP, addi->ADDI_EXEC, HALT_OP->HALT, other->HALT with illegal_op<=1.
// - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw->MEM_READ, sw->MEM_WRITE.
// - MEM_READ: mem_read=1, ior=1; stay until mem_ready, then MEM_WB. MEM_WB: reg_write=1, memto_reg=1, reg_dst=0 -> FETCH.
// - MEM_WRITE: mem_write=1, ior=1; stay until mem_ready, then -> FETCH.
// - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB: reg_write=1, reg_dst=1, memto_reg=0 -> FETCH.
// - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH (1 cycle, taken or not).
// - JUMP: pc_write=1, pc_source=10 -> FETCH. ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB:
//   reg_write=1, reg_dst=0, memto_reg=0 -> FETCH.
// - HALT: terminal; all strobes 0, halted=1; leaves only on reset. HALT_OP/illegal not counted as retired.
// - Strobes default 0 in any state not listing them; mem_read and mem_write never both 1.
// - instr_count +1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB.
// - cycle_count +1 every cycle state!=HALT. Both saturate at all-ones (no wrap).
// - Latencies with mem_ready tied 1: R/addi 4, lw 5, sw 4, beq 3, j 3 cycles. Each mem wait cycle adds 1.
// - reset mid-access: FSM returns to FETCH immediately; pending memory request dropped (mem_read/mem_write 0).
// STRUCTURE
// - Shared package mips_pkg: opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), state enum
//   (4-bit), alu_op and alu_src_b / pc_source encodings; datapath top imports the same constants.
// - One sub-module: mips_perf_counters (saturating instr/cycle counters, inputs retire + active).
// - FSM: registered state, combinational next-state and output decode (mem_ready-qualified strobes in FETCH).
// TESTING
// - Program add;lw;sw;beq(taken);j;addi with mem_ready=1 -> state traces 4/5/4/3/3/4 cycles, instr_count=6.
// - FETCH with mem_ready low 3 cycles -> ir_write/pc_write stay 0, then pulse exactly once in cycle 4.
// - beq with alu_zero=0 -> pc_write_cond=1 but PC unchanged; alu_zero=1 -> PC=ALUOut target.
// - Opcode 6'b010101 -> HALT, illegal_op=1, halted=1, cycle_count frozen, instr_count unchanged.
// - reset asserted during MEM_READ wait -> all strobes 0 async; after release state=FETCH, counters 0.
// - CNT_W=4, run 20 instructions -> instr_count=15 and cycle_count=15 held (saturation).

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// mips_pkg -- shared opcode, state and mux-select encodings for the 16-bit multi-cycle MIPS core. Rev 1.0
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11,
    ST_HALT      = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ior;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if -- control bus between the multi-cycle sequencer and the datapath/memory port. Rev 1.0
`default_nettype none

interface mips_multicycle_ctrl_if;

  logic [5:0] opcode;
  logic       alu_zero;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       ior;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       memto_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output pc_write, pc_write_cond, pc_source, ior, mem_read, mem_write,
           ir_write, reg_dst, memto_reg, reg_write, alu_src_a, alu_src_b, alu_op
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  pc_write, pc_write_cond, pc_source, ior, mem_read, mem_write,
           ir_write, reg_dst, memto_reg, reg_write, alu_src_a, alu_src_b, alu_op
  );

endinterface

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_perf_counters.sv
// mips_perf_counters -- saturating retired-instruction and active-cycle counters. Rev 1.0
`default_nettype none

module mips_perf_counters #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             retire,
  input  logic             active,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;

  always_comb begin
    instr_d = instr_q;
    cycle_d = cycle_q;
    if (retire && (instr_q != CNT_MAX)) instr_d = instr_q + CNT_ONE;
    if (active && (cycle_q != CNT_MAX)) cycle_d = cycle_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      cycle_q <= '0;
    end else begin
      instr_q <= instr_d;
      cycle_q <= cycle_d;
    end
  end

  assign instr_count = instr_q;
  assign cycle_count = cycle_q;

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl -- multi-cycle sequencer time-sharing one ALU and one memory port. Rev 1.0
`default_nettype none

module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int         CNT_W   = 16,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus,
  output logic                   halted,
  output logic                   illegal_op,
  output logic [CNT_W-1:0]       instr_count,
  output logic [CNT_W-1:0]       cycle_count
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl_out;
  logic   retire;
  logic   active;
  logic   unused_alu_zero;

  // beq outcome is resolved in the datapath (pc_write_cond AND alu_zero)
  assign unused_alu_zero = bus.alu_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    ctrl_raw  = '0;

    unique case (state_q)
      ST_FETCH: begin
        ctrl_raw.mem_read  = 1'b1;
        ctrl_raw.alu_src_b = SRCB_ONE;
        ctrl_raw.alu_op    = ALU_OP_ADD;
        ctrl_raw.pc_source = PCSRC_ALU;
        if (bus.mem_ready) begin
          ctrl_raw.ir_write = 1'b1;
          ctrl_raw.pc_write = 1'b1;
          state_d           = ST_DECODE;
        end
      end

      ST_DECODE: begin
        ctrl_raw.alu_src_b = SRCB_BROFF;
        ctrl_raw.alu_op    = ALU_OP_ADD;
        if (is_mem_op(bus.opcode)) begin
          state_d = ST_MEM_ADDR;
        end else begin
          case (bus.opcode)
            OP_RTYPE: state_d = ST_EXECUTE;
            OP_BEQ:   state_d = ST_BRANCH;
            OP_J:     state_d = ST_JUMP;
            OP_ADDI:  state_d = ST_ADDI_EXEC;
            default: begin
              state_d = ST_HALT;
              if (bus.opcode != HALT_OP) illegal_d = 1'b1;
            end
          endcase
        end
      end

      ST_MEM_ADDR: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = SRCB_IMM;
        ctrl_raw.alu_op    = ALU_OP_ADD;
        state_d = (bus.opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      end

      ST_MEM_READ: begin
        ctrl_raw.mem_read = 1'b1;
        ctrl_raw.ior      = 1'b1;
        if (bus.mem_ready) state_d = ST_MEM_WB;
      end

      ST_MEM_WB: begin
        ctrl_raw.reg_write = 1'b1;
        ctrl_raw.memto_reg = 1'b1;
        state_d            = ST_FETCH;
      end

      ST_MEM_WRITE: begin
        ctrl_raw.mem_write = 1'b1;
        ctrl_raw.ior       = 1'b1;
        if (bus.mem_ready) state_d = ST_FETCH;
      end

      ST_EXECUTE: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = SRCB_REGB;
        ctrl_raw.alu_op    = ALU_OP_FUNCT;
        state_d            = ST_R_WB;
      end

      ST_R_WB: begin
        ctrl_raw.reg_write = 1'b1;
        ctrl_raw.reg_dst   = 1'b1;
        state_d            = ST_FETCH;
      end

      ST_BRANCH: begin
        ctrl_raw.alu_src_a     = 1'b1;
        ctrl_raw.alu_src_b     = SRCB_REGB;
        ctrl_raw.alu_op        = ALU_OP_SUB;
        ctrl_raw.pc_write_cond = 1'b1;
        ctrl_raw.pc_source     = PCSRC_ALUOUT;
        state_d                = ST_FETCH;
      end

      ST_JUMP: begin
        ctrl_raw.pc_write  = 1'b1;
        ctrl_raw.pc_source = PCSRC_JUMP;
        state_d            = ST_FETCH;
      end

      ST_ADDI_EXEC: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = SRCB_IMM;
        ctrl_raw.alu_op    = ALU_OP_ADD;
        state_d            = ST_ADDI_WB;
      end

      ST_ADDI_WB: begin
        ctrl_raw.reg_write = 1'b1;
        state_d            = ST_FETCH;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_FETCH;
    endcase
  end

  // Strobes are forced low combinationally so a reset mid-access drops the request at once
  assign ctrl_out = reset ? '0 : ctrl_raw;

  assign bus.pc_write      = ctrl_out.pc_write;
  assign bus.pc_write_cond = ctrl_out.pc_write_cond;
  assign bus.pc_source     = ctrl_out.pc_source;
  assign bus.ior           = ctrl_out.ior;
  assign bus.mem_read      = ctrl_out.mem_read;
  assign bus.mem_write     = ctrl_out.mem_write;
  assign bus.ir_write      = ctrl_out.ir_write;
  assign bus.reg_dst       = ctrl_out.reg_dst;
  assign bus.memto_reg     = ctrl_out.memto_reg;
  assign bus.reg_write     = ctrl_out.reg_write;
  assign bus.alu_src_a     = ctrl_out.alu_src_a;
  assign bus.alu_src_b     = ctrl_out.alu_src_b;
  assign bus.alu_op        = ctrl_out.alu_op;

  assign halted     = (state_q == ST_HALT) && !reset;
  assign illegal_op = illegal_q;

  // Every completing instruction path ends with a transition back into FETCH
  assign retire = (state_q != ST_FETCH) && (state_d == ST_FETCH);
  assign active = (state_q != ST_HALT);

  mips_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk         (clk),
    .reset       (reset),
    .retire      (retire),
    .active      (active),
    .instr_count (instr_count),
    .cycle_count (cycle_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl -- scoreboard bench: stimulus queues per-cycle expectations, negedge monitor checks them. Rev 1.0
`default_nettype none

module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  localparam int         CNT_W   = 6;
  localparam int         CMAX    = (1 << CNT_W) - 1;
  localparam logic [5:0] HALT_OP = 6'b111111;
  localparam logic [5:0] OP_BAD  = 6'b010101;

  localparam int S_FWAIT = 0,  S_FDONE = 1,  S_DECODE = 2, S_MEMADDR = 3, S_MEMRD = 4;
  localparam int S_MEMWB = 5,  S_MEMWR = 6,  S_EXEC = 7,   S_RWB = 8,     S_BR = 9;
  localparam int S_JMP   = 10, S_ADDI = 11,  S_ADDIWB = 12, S_HALT = 13,  S_RESET = 14;

  typedef struct {
    logic [17:0] word;
    int          ic;
    int          cc;
    int          step;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             halted;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(
    .CNT_W   (CNT_W),
    .HALT_OP (HALT_OP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .instr_count (instr_count),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       sb[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         m_ret       = 0;
  int         m_cyc       = 0;
  logic       m_ill       = 1'b0;
  logic [5:0] cur_op      = 6'b0;
  logic [5:0] ops[6]      = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

  // {illegal, halted, pc_write, pc_write_cond, pc_source, ior, mem_read, mem_write,
  //  ir_write, reg_dst, memto_reg, reg_write, alu_src_a, alu_src_b, alu_op}
  function automatic logic [17:0] mk(input logic hlt, pcw, pcwc, input logic [1:0] pcs,
                                     input logic ior, mr, mw, irw, rdst, m2r, rw, asa,
                                     input logic [1:0] asb, aop);
    return {1'b0, hlt, pcw, pcwc, pcs, ior, mr, mw, irw, rdst, m2r, rw, asa, asb, aop};
  endfunction

  function automatic logic [17:0] step_word(input int s);
    case (s)
      S_FWAIT:   return mk(0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00);
      S_FDONE:   return mk(0, 1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00);
      S_DECODE:  return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00);
      S_MEMADDR: return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00);
      S_MEMRD:   return mk(0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      S_MEMWB:   return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00);
      S_MEMWR:   return mk(0, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      S_EXEC:    return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10);
      S_RWB:     return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00);
      S_BR:      return mk(0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01);
      S_JMP:     return mk(0, 1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      S_ADDI:    return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00);
      S_ADDIWB:  return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00);
      S_HALT:    return mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      default:   return 18'h0;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock of stimulus; the expectation for that clock is queued for the monitor
  task automatic cyc(input int s, input logic rdy, input logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.mem_ready = rdy;
    bus.opcode    = cur_op;
    bus.alu_zero  = rnd();
    if (rst) begin
      m_ret = 0;
      m_cyc = 0;
      m_ill = 1'b0;
    end
    e.word = rst ? 18'h0 : (step_word(s) | {m_ill, 17'h0});
    e.ic   = sat(m_ret);
    e.cc   = sat(m_cyc);
    e.step = s;
    sb.push_back(e);
    if (!rst && s != S_HALT) m_cyc++;
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wd);
    logic retires;
    retires = 1'b1;
    cur_op  = op;
    for (int i = 0; i < wf; i++) cyc(S_FWAIT, 1'b0, 1'b0);
    cyc(S_FDONE, 1'b1, 1'b0);
    cyc(S_DECODE, rnd(), 1'b0);
    case (op)
      OP_RTYPE: begin cyc(S_EXEC, rnd(), 1'b0); cyc(S_RWB, rnd(), 1'b0); end
      OP_LW: begin
        cyc(S_MEMADDR, rnd(), 1'b0);
        for (int i = 0; i < wd; i++) cyc(S_MEMRD, 1'b0, 1'b0);
        cyc(S_MEMRD, 1'b1, 1'b0);
        cyc(S_MEMWB, rnd(), 1'b0);
      end
      OP_SW: begin
        cyc(S_MEMADDR, rnd(), 1'b0);
        for (int i = 0; i < wd; i++) cyc(S_MEMWR, 1'b0, 1'b0);
        cyc(S_MEMWR, 1'b1, 1'b0);
      end
      OP_BEQ:  cyc(S_BR, rnd(), 1'b0);
      OP_J:    cyc(S_JMP, rnd(), 1'b0);
      OP_ADDI: begin cyc(S_ADDI, rnd(), 1'b0); cyc(S_ADDIWB, rnd(), 1'b0); end
      default: begin
        retires = 1'b0;
        if (op != HALT_OP) m_ill = 1'b1;
      end
    endcase
    if (retires) m_ret++;
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(S_HALT, rnd(), 1'b0);
  endtask

  // Monitor: pops one expectation per clock that the stimulus produced
  exp_t        mon_e;
  logic [17:0] mon_obs;
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e   = sb.pop_front();
      mon_obs = {illegal_op, halted, bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.ior,
                 bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst, bus.memto_reg,
                 bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op};
      vectors++;
      if (mon_obs !== mon_e.word || instr_count !== CNT_W'(mon_e.ic) ||
          cycle_count !== CNT_W'(mon_e.cc)) begin
        miscompares++;
        $display("FAIL vec%0d step%0d: strobes=%h want %h, instr_count=%0d want %0d, cycle_count=%0d want %0d",
                 vectors, mon_e.step, mon_obs, mon_e.word, instr_count, mon_e.ic,
                 cycle_count, mon_e.cc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.opcode    = 6'b0;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b0;

    cyc(S_RESET, 1'b0, 1'b1);
    cyc(S_RESET, 1'b1, 1'b1);

    // Zero-wait program: 4/5/4/3/3/4 cycles
    run_instr(OP_RTYPE, 0, 0);
    run_instr(OP_LW,    0, 0);
    run_instr(OP_SW,    0, 0);
    run_instr(OP_BEQ,   0, 0);
    run_instr(OP_J,     0, 0);
    run_instr(OP_ADDI,  0, 0);
    run_instr(OP_RTYPE, 3, 0);

    // Long random run drives both counters into saturation
    for (int n = 0; n < 75; n++)
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3));

    // Reset while a load waits on memory
    cur_op = OP_LW;
    cyc(S_FDONE, 1'b1, 1'b0);
    cyc(S_DECODE, rnd(), 1'b0);
    cyc(S_MEMADDR, rnd(), 1'b0);
    cyc(S_MEMRD, 1'b0, 1'b0);
    cyc(S_RESET, 1'b0, 1'b1);
    cyc(S_RESET, rnd(), 1'b1);
    run_instr(OP_SW, 1, 2);
    run_instr(OP_BEQ, 0, 0);

    run_instr(OP_BAD, 0, 0);
    halt_cycles(6);

    cyc(S_RESET, 1'b0, 1'b1);
    run_instr(OP_ADDI, 2, 0);
    run_instr(HALT_OP, 0, 0);
    halt_cycles(4);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
